// File: rtl/line_decoder_pkg.sv
// Shared widths, the one-hot base constant and the decode function for line_decoder.
package line_decoder_pkg;

   localparam int unsigned SEL_W = 3;
   localparam int unsigned OUT_W = 8;

   // Line 7 is the target of select 0; higher selects walk toward line 0.
   localparam logic [OUT_W-1:0] ONE_HOT_BASE = OUT_W'(8'b1000_0000);

   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [OUT_W-1:0] line_t;

   // One-hot decode. An unknown select while enabled propagates as unknown
   // through the shift, so X on a select line is never masked.
   function automatic line_t decode(input logic en, input sel_t sel);
      line_t res;
      res = '0;
      if (en) begin
         res = ONE_HOT_BASE >> sel;
      end
      return res;
   endfunction

endpackage

// File: rtl/line_decoder_core.sv
// Purely combinational 3-to-8 one-hot decode with active-high enable.
module line_decoder_core
   import line_decoder_pkg::*;
(
   input  logic  en,
   input  sel_t  sel,
   output line_t lines
);

   // Decode select to a single active line, or all lines low when disabled.
   always_comb begin
      lines = decode(en, sel);
   end

endmodule

// File: rtl/line_decoder.sv
// line_decoder: 3-to-8 one-hot decoder with a live combinational output F,
// a one-cycle registered copy F_q, and (with LINE_DECODER_SEEN_EN defined)
// a sticky activity mask seen that accumulates every line F_q has driven.
module line_decoder
   import line_decoder_pkg::*;
(
   input  logic             Enable,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   output logic [OUT_W-1:0] F,
   input  logic             clk,
   input  logic             rst_n,
   output logic [OUT_W-1:0] F_q
`ifdef LINE_DECODER_SEEN_EN
   ,
   output logic [OUT_W-1:0] seen
`endif
);

   sel_t  sel_c;
   line_t out_d;
   line_t out_q;

   // Select index with A as the most significant bit.
   always_comb begin
      sel_c = {A, B, C};
   end

   // Combinational decode path; independent of clk and rst_n.
   line_decoder_core u_core (
      .en    (Enable),
      .sel   (sel_c),
      .lines (F)
   );

   // Registered copy simply follows the live decode.
   always_comb begin
      out_d = F;
   end

   // Registered output; cleared asynchronously while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign F_q = out_q;

`ifdef LINE_DECODER_SEEN_EN
   line_t seen_d;
   line_t seen_q;

   // Sticky mask includes the value F_q takes on this edge, so seen always
   // equals the OR of every F_q value since reset.
   always_comb begin
      seen_d = seen_q | out_d;
   end

   // Sticky flops; bits only ever clear through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q <= '0;
      end else begin
         seen_q <= seen_d;
      end
   end

   assign seen = seen_q;
`endif

endmodule

// File: tb/tb_line_decoder.sv
// Self-checking bench for line_decoder: stimulus pushes expectations into a
// scoreboard queue, a monitor pops and compares against the DUT outputs.
module tb_line_decoder;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic       Enable = 1'b0;
   logic       A      = 1'b0;
   logic       B      = 1'b0;
   logic       C      = 1'b0;
   logic [7:0] F;
   logic [7:0] F_q;
`ifdef LINE_DECODER_SEEN_EN
   logic [7:0] seen;
`endif

   bit clk_run = 1'b0;

   line_decoder dut (
      .Enable (Enable),
      .A      (A),
      .B      (B),
      .C      (C),
      .F      (F),
      .clk    (clk),
      .rst_n  (rst_n),
      .F_q    (F_q)
`ifdef LINE_DECODER_SEEN_EN
      ,
      .seen   (seen)
`endif
   );

   // Gateable clock, period 10.
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   typedef enum int {CHK_F, CHK_FQ, CHK_SEEN} chk_e;
   typedef struct {
      chk_e       kind;
      logic [7:0] exp;
      string      tag;
   } item_t;

   item_t      sb_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   bit         cur_en   = 1'b0;
   int         cur_s    = 0;
   logic [7:0] fq_model   = 8'h00;
   logic [7:0] seen_model = 8'h00;

   // Reference: exactly line (7 - S) is high when enabled, nothing otherwise.
   function automatic logic [7:0] ref_decode(bit en, int s);
      logic [7:0] v;
      v = 8'h00;
      if (en) v[7 - s] = 1'b1;
      return v;
   endfunction

   // Monitor: pop each expectation and compare with the named DUT output.
   initial begin : monitor
      item_t      it;
      logic [7:0] act;
      forever begin
         wait (sb_q.size() != 0);
         it = sb_q.pop_front();
         case (it.kind)
            CHK_F:  act = F;
            CHK_FQ: act = F_q;
            default: begin
`ifdef LINE_DECODER_SEEN_EN
               act = seen;
`else
               act = 8'h00;
`endif
            end
         endcase
         n_checks++;
         if (act !== it.exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b at %0t", it.tag, act, it.exp, $time);
         end
      end
   end

   task automatic apply(bit en, int s);
      cur_en = en;
      cur_s  = s;
      Enable = en;
      {A, B, C} = 3'(s);
   endtask

   task automatic push(chk_e k, logic [7:0] e, string tag);
      item_t it;
      it.kind = k;
      it.exp  = e;
      it.tag  = tag;
      sb_q.push_back(it);
   endtask

   // Push expectations for all registered outputs against the model.
   task automatic push_regs(string tag);
      push(CHK_FQ, fq_model, {tag, "_fq"});
`ifdef LINE_DECODER_SEEN_EN
      push(CHK_SEEN, seen_model, {tag, "_seen"});
`endif
   endtask

   // Drive inputs on the falling edge, update the model at the rising edge,
   // then check F, F_q and seen one unit later.
   task automatic tick(bit en, int s, bit rel, string tag);
      @(negedge clk);
      if (rel) rst_n = 1'b1;
      apply(en, s);
      @(posedge clk);
      if (rst_n) begin
         fq_model   = ref_decode(en, s);
         seen_model = seen_model | fq_model;
      end
      #1;
      push(CHK_F, ref_decode(en, s), {tag, "_f"});
      push_regs(tag);
      #1;
   endtask

   task automatic async_reset(string tag);
      rst_n = 1'b0;
      #1;
      fq_model   = 8'h00;
      seen_model = 8'h00;
      push_regs(tag);
      push(CHK_F, ref_decode(cur_en, cur_s), {tag, "_flive"});
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb_q.size());
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit pending_rel;
      // Reset with no clock running: registered outputs clear at once.
      #1;
      rst_n = 1'b0;
      #1;
      push_regs("reset_now");
      #20;
      push_regs("reset_hold");

      // Directed decode while still in reset: F decodes live.
      apply(1'b1, 2);
      #5;
      push(CHK_F, 8'b0010_0000, "dir_s2");
      #1;
      for (int s = 0; s < 8; s++) begin
         apply(1'b1, s);
         #5;
         push(CHK_F, ref_decode(1'b1, s), $sformatf("sweep_en_s%0d", s));
         #1;
      end
      apply(1'b1, 0);
      #5;
      push(CHK_F, 8'b1000_0000, "edge_s0");
      #1;
      apply(1'b1, 7);
      #5;
      push(CHK_F, 8'b0000_0001, "edge_s7");
      #1;
      for (int s = 0; s < 8; s++) begin
         apply(1'b0, s);
         #5;
         push(CHK_F, 8'h00, $sformatf("sweep_dis_s%0d", s));
         #1;
      end
      push_regs("reset_after_sweep");
      #1;

      // Start the clock while held in reset, then release and load S=3.
      clk_run = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      push_regs("reset_clocked");
      #1;
      tick(1'b1, 3, 1'b1, "release_s3");
      push(CHK_FQ, 8'b0001_0000, "release_s3_const");
      #1;

      // Mid-operation reset pulse, then S=0 and S=7 accumulate into seen.
      async_reset("mid_reset");
      tick(1'b1, 0, 1'b1, "seen_s0");
      tick(1'b1, 7, 1'b0, "seen_s7");
`ifdef LINE_DECODER_SEEN_EN
      push(CHK_SEEN, 8'b1000_0001, "seen_const");
      #1;
      async_reset("seen_pulse");
      tick(1'b0, 0, 1'b1, "seen_after_pulse");
`endif

      // Randomized operation with occasional asynchronous reset pulses.
      pending_rel = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), pending_rel,
              $sformatf("rnd%0d", i));
         pending_rel = 1'b0;
         if ($urandom_range(0, 15) == 0) begin
            async_reset($sformatf("rnd_rst%0d", i));
            pending_rel = 1'b1;
         end
      end
      if (pending_rel) tick(1'b1, 5, 1'b1, "final_release");

      // Drain the scoreboard with a bounded wait.
      for (int w = 0; w < 100 && sb_q.size() != 0; w++) #1;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: actual %0d pending required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
